ex_stage: RTL
=============

# ex_stage

Execute stage of the five-stage pipeline. It takes the 3-bit ALU control code from the ALU decoder along with the ID/EX operands and control bits, and resolves operand forwarding from MEM and WB. It then performs the ALU operation and registers the result and the surviving control into the EX/MEM pipeline register. Stall and flush from the hazard unit act on that register.

## Interface
- WIDTH, 32, datapath width
- REGADDR, 5, register-file address width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- stall_i  in  1  hold EX/MEM register contents
- flush_i  in  1  load a bubble into EX/MEM
- id_valid_i  in  1  ID/EX holds a real instruction
- alucontrol_i  in  3  ALU code: 010 add, 110 sub, 000 and, 001 or, 111 slt
- srca_i, srcb_i  in  WIDTH  register operands from ID/EX
- imm_i  in  WIDTH  sign-extended immediate
- alusrc_i  in  1  1 selects imm_i as ALU operand B
- fwd_a_i, fwd_b_i  in  2  forward select: 00 register, 01 WB result, 10 MEM result, 11 treated as 00
- mem_result_i, wb_result_i  in  WIDTH  forwarding sources
- regwrite_i, memtoreg_i, memwrite_i, branch_i  in  1  control bits from ID/EX
- writereg_i  in  REGADDR  destination register
- valid_o  out  1  EX/MEM holds a real instruction
- aluout_o  out  WIDTH  registered ALU result
- writedata_o  out  WIDTH  forwarded operand B, taken before the immediate mux (store data)
- zero_o  out  1  registered result==0
- regwrite_o, memtoreg_o, memwrite_o, branch_o  out  1  registered control
- writereg_o  out  REGADDR  registered destination
- ovf_o  out  1  registered signed overflow (see Configuration)

## Operation
- Operand A = fwd_a_i mux of {srca_i, wb_result_i, mem_result_i}.
- Forwarded B (fb) = same mux on srcb_i using fwd_b_i.
- ALU operand B = alusrc_i ? imm_i : fb.
- ALU operations:
  - add: A+B, mod 2^WIDTH.
  - sub: A−B, mod 2^WIDTH.
  - and, or: bitwise.
  - slt: signed compare, result {WIDTH-1 zeros, A<B}.
  - Codes 011, 100, 101: result 0.
- zero = (result == 0).
- Register update priority on each rising edge: reset > flush > stall > load.
  - Reset or flush: load a bubble. All outputs go to 0, including valid_o, regwrite_o, memwrite_o and ovf_o.
  - Stall (without flush): every output holds its current value.
  - Load, id_valid_i=1: capture result, fb, zero, control and writereg. Set valid_o=1.
  - Load, id_valid_i=0: load a bubble.
- The datapath is combinational between ID/EX and EX/MEM. This block holds no other state.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
- Reset value of every output is 0.
- flush_i and stall_i asserted together: flush wins and a bubble is loaded.
- rst_n low mid-stall: outputs clear at the next edge regardless of stall_i.
- Forwarding inputs are sampled in the same cycle as the operands. There is no internal bypass; the hazard unit owns the fwd selects.
- Stall for K cycles: outputs are unchanged for K edges. The instruction present at the first non-stalled edge is loaded.

## Configuration
- EX_OVERFLOW_EN defined:
  - Signed overflow is computed for add (operands share a sign and the result sign differs) and for sub (operands differ in sign and the result sign differs from A).
  - The flag is registered into ovf_o.
  - On overflow, regwrite_o is forced to 0 for that instruction. The remaining outputs load normally.
- EX_OVERFLOW_EN undefined:
  - ovf_o is tied to 0.
  - Arithmetic wraps silently and regwrite_o passes through unmodified.
- The port list is identical in both builds.

## Test plan
- Add with WB forwarding: srca_i=0, wb_result_i=5, fwd_a_i=01, srcb_i=7, alucontrol_i=010, id_valid_i=1 -> after one edge, aluout_o=12, zero_o=0, valid_o=1.
- Beq subtract: A=0x10, B=0x10, alucontrol_i=110, branch_i=1 -> aluout_o=0, zero_o=1, branch_o=1.
- Signed slt with immediate and store data: A=0xFFFFFFFF, alusrc_i=1, imm_i=1, alucontrol_i=111, srcb_i=0xAB -> aluout_o=1, writedata_o=0xAB.
- Stall then flush:
  - Load add result 3, then hold stall_i=1 for 3 edges with changing inputs -> aluout_o stays 3.
  - Then assert stall_i=1 and flush_i=1 together -> all outputs 0.
- Overflow: A=0x7FFFFFFF, B=1, alucontrol_i=010, regwrite_i=1.
  - With EX_OVERFLOW_EN -> ovf_o=1, regwrite_o=0, aluout_o=0x80000000.
  - Without -> ovf_o=0, regwrite_o=1.
- Reset: drive a valid load, then rst_n=0 for one edge while stall_i=1 -> every output 0.

Source files
------------

// File: rtl/ex_stage_if.sv
// Execute-stage bundle: ID/EX operands, forwarding sources, hazard controls and EX/MEM outputs.
// master drives the ID/EX side and hazard controls; slave is the execute stage itself.
interface ex_stage_if #(
   parameter int WIDTH   = 32,
   parameter int REGADDR = 5
);
   logic               stall_i;
   logic               flush_i;
   logic               id_valid_i;
   logic [2:0]         alucontrol_i;
   logic [WIDTH-1:0]   srca_i;
   logic [WIDTH-1:0]   srcb_i;
   logic [WIDTH-1:0]   imm_i;
   logic               alusrc_i;
   logic [1:0]         fwd_a_i;
   logic [1:0]         fwd_b_i;
   logic [WIDTH-1:0]   mem_result_i;
   logic [WIDTH-1:0]   wb_result_i;
   logic               regwrite_i;
   logic               memtoreg_i;
   logic               memwrite_i;
   logic               branch_i;
   logic [REGADDR-1:0] writereg_i;

   logic               valid_o;
   logic [WIDTH-1:0]   aluout_o;
   logic [WIDTH-1:0]   writedata_o;
   logic               zero_o;
   logic               regwrite_o;
   logic               memtoreg_o;
   logic               memwrite_o;
   logic               branch_o;
   logic [REGADDR-1:0] writereg_o;
   logic               ovf_o;

   modport master (
      output stall_i, flush_i, id_valid_i, alucontrol_i, srca_i, srcb_i, imm_i, alusrc_i,
             fwd_a_i, fwd_b_i, mem_result_i, wb_result_i, regwrite_i, memtoreg_i,
             memwrite_i, branch_i, writereg_i,
      input  valid_o, aluout_o, writedata_o, zero_o, regwrite_o, memtoreg_o, memwrite_o,
             branch_o, writereg_o, ovf_o
   );

   modport slave (
      input  stall_i, flush_i, id_valid_i, alucontrol_i, srca_i, srcb_i, imm_i, alusrc_i,
             fwd_a_i, fwd_b_i, mem_result_i, wb_result_i, regwrite_i, memtoreg_i,
             memwrite_i, branch_i, writereg_i,
      output valid_o, aluout_o, writedata_o, zero_o, regwrite_o, memtoreg_o, memwrite_o,
             branch_o, writereg_o, ovf_o
   );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes + ALU into the EX/MEM register; 1-cycle latency, stall holds, flush bubbles.
// Optional signed-overflow trap (suppresses regwrite) enabled by defining EX_OVERFLOW_EN.
module ex_stage #(
   parameter int WIDTH   = 32,
   parameter int REGADDR = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   ex_stage_if.slave  bus
);
   localparam int MSB = WIDTH - 1;

   logic [WIDTH-1:0]   w_a;
   logic [WIDTH-1:0]   w_fb;
   logic [WIDTH-1:0]   w_b;
   logic [WIDTH-1:0]   w_res;
   logic               w_zero;
   logic               w_ovf;
   logic               w_regwrite;

   logic               r_valid;
   logic [WIDTH-1:0]   r_aluout;
   logic [WIDTH-1:0]   r_writedata;
   logic               r_zero;
   logic               r_regwrite;
   logic               r_memtoreg;
   logic               r_memwrite;
   logic               r_branch;
   logic [REGADDR-1:0] r_writereg;
   logic               r_ovf;

   // Select 11 deliberately falls back to the register operand.
   always_comb begin
      case (bus.fwd_a_i)
         2'b01:   w_a = bus.wb_result_i;
         2'b10:   w_a = bus.mem_result_i;
         default: w_a = bus.srca_i;
      endcase
      case (bus.fwd_b_i)
         2'b01:   w_fb = bus.wb_result_i;
         2'b10:   w_fb = bus.mem_result_i;
         default: w_fb = bus.srcb_i;
      endcase
   end

   assign w_b = bus.alusrc_i ? bus.imm_i : w_fb;

   always_comb begin
      case (bus.alucontrol_i)
         3'b010:  w_res = w_a + w_b;
         3'b110:  w_res = w_a - w_b;
         3'b000:  w_res = w_a & w_b;
         3'b001:  w_res = w_a | w_b;
         3'b111:  w_res = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
         default: w_res = '0;
      endcase
   end

   assign w_zero = (w_res == '0);

`ifdef EX_OVERFLOW_EN
   always_comb begin
      case (bus.alucontrol_i)
         3'b010:  w_ovf = (w_a[MSB] == w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
         3'b110:  w_ovf = (w_a[MSB] != w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
         default: w_ovf = 1'b0;
      endcase
   end
`else
   assign w_ovf = 1'b0;
`endif

   // An overflowing instruction still flows down the pipe, it just never retires a write.
   assign w_regwrite = bus.regwrite_i & ~w_ovf;

   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush_i || (!bus.stall_i && !bus.id_valid_i)) begin
         r_valid     <= 1'b0;
         r_aluout    <= '0;
         r_writedata <= '0;
         r_zero      <= 1'b0;
         r_regwrite  <= 1'b0;
         r_memtoreg  <= 1'b0;
         r_memwrite  <= 1'b0;
         r_branch    <= 1'b0;
         r_writereg  <= '0;
         r_ovf       <= 1'b0;
      end else if (!bus.stall_i) begin
         r_valid     <= 1'b1;
         r_aluout    <= w_res;
         r_writedata <= w_fb;
         r_zero      <= w_zero;
         r_regwrite  <= w_regwrite;
         r_memtoreg  <= bus.memtoreg_i;
         r_memwrite  <= bus.memwrite_i;
         r_branch    <= bus.branch_i;
         r_writereg  <= bus.writereg_i;
         r_ovf       <= w_ovf;
      end
   end

   assign bus.valid_o     = r_valid;
   assign bus.aluout_o    = r_aluout;
   assign bus.writedata_o = r_writedata;
   assign bus.zero_o      = r_zero;
   assign bus.regwrite_o  = r_regwrite;
   assign bus.memtoreg_o  = r_memtoreg;
   assign bus.memwrite_o  = r_memwrite;
   assign bus.branch_o    = r_branch;
   assign bus.writereg_o  = r_writereg;
   assign bus.ovf_o       = r_ovf;
endmodule
